// File: rtl/ysyx2400012_lsu_pkg.sv
// ysyx2400012 LSU shared types: access sizes, FSM states and memory window.
// Also provides the access-size to byte-count helper.
package ysyx2400012_lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_ILL  = 2'd3;

    localparam logic [31:0] LSU_ORIGIN_ADDR = 32'h8000_0000;
    localparam logic [31:0] LSU_MEM_SIZE    = 32'h0800_0000;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STORE,
        RESP
    } lsu_state_e;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/ysyx2400012_load_align.sv
// ysyx2400012 load data aligner: picks the addressed byte/half out of a
// memory word and sign- or zero-extends it.
module ysyx2400012_load_align
    import ysyx2400012_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] word,
    input  logic [1:0]            offset,
    input  logic [1:0]            size,
    input  logic                  is_unsigned,
    output logic [DATA_WIDTH-1:0] data
);

    logic [DATA_WIDTH-1:0] shifted;
    logic                  sign;

    always_comb begin
        shifted = word >> {offset, 3'b000};
        sign    = 1'b0;
        data    = word;
        case (size)
            SZ_BYTE: begin
                sign = !is_unsigned && shifted[7];
                data = {{(DATA_WIDTH-8){sign}}, shifted[7:0]};
            end
            SZ_HALF: begin
                sign = !is_unsigned && shifted[15];
                data = {{(DATA_WIDTH-16){sign}}, shifted[15:0]};
            end
            default: data = word;
        endcase
    end

endmodule

// File: rtl/ysyx2400012_lsu.sv
// ysyx2400012 load/store unit: one request at a time, single-cycle memory
// access, response held until the core consumes it.
module ysyx2400012_lsu
    import ysyx2400012_lsu_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] ORIGIN_ADDR = ADDR_WIDTH'(LSU_ORIGIN_ADDR),
    parameter logic [ADDR_WIDTH-1:0] MEM_SIZE    = ADDR_WIDTH'(LSU_MEM_SIZE)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic [DATA_WIDTH-1:0] mem_wr_len
);

    // One extra bit so the end-of-window compare never wraps.
    localparam logic [ADDR_WIDTH:0] MEM_END = {1'b0, ORIGIN_ADDR} + {1'b0, MEM_SIZE};

    lsu_state_e            state;
    lsu_state_e            state_next;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] load_data;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic                  err_q;
    logic                  accept;
    logic                  misaligned;
    logic                  req_err;
    logic [2:0]            req_bytes;
    logic [ADDR_WIDTH:0]   req_end;

    assign req_ready  = reset && (state == IDLE);
    assign accept     = req_valid && req_ready;
    assign req_bytes  = size_bytes(req_size);
    assign req_end    = {1'b0, req_addr} + {{(ADDR_WIDTH-2){1'b0}}, req_bytes};
    assign misaligned = ((req_size == SZ_HALF) && req_addr[0])
                     || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    assign req_err    = (req_size == SZ_ILL) || misaligned
                     || (req_addr < ORIGIN_ADDR) || (req_end > MEM_END);

    ysyx2400012_load_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_align (
        .word       (mem_rd_data),
        .offset     (addr_q[1:0]),
        .size       (size_q),
        .is_unsigned(uns_q),
        .data       (load_data)
    );

    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            err_q   <= req_err;
            rdata_q <= '0;
        end else if (state == LOAD) begin
            rdata_q <= load_data;
        end
    end

    // Every output is gated by reset so an interrupted access leaves no trace.
    always_comb begin
        state_next  = state;
        resp_valid  = 1'b0;
        resp_rdata  = '0;
        resp_err    = 1'b0;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        mem_wr_en   = 1'b0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        mem_wr_len  = '0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)      state_next = RESP;
                    else if (req_wen) state_next = STORE;
                    else              state_next = LOAD;
                end
            end
            LOAD: begin
                state_next  = RESP;
                mem_rd_en   = reset;
                mem_rd_addr = reset ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
            end
            STORE: begin
                state_next = RESP;
                if (reset) begin
                    mem_wr_en   = 1'b1;
                    mem_wr_addr = addr_q;
                    mem_wr_len  = {{(DATA_WIDTH-3){1'b0}}, size_bytes(size_q)};
                    case (size_q)
                        SZ_BYTE: mem_wr_data = {{(DATA_WIDTH-8){1'b0}}, wdata_q[7:0]};
                        SZ_HALF: mem_wr_data = {{(DATA_WIDTH-16){1'b0}}, wdata_q[15:0]};
                        default: mem_wr_data = wdata_q;
                    endcase
                end
            end
            RESP: begin
                if (resp_ready) state_next = IDLE;
                if (reset) begin
                    resp_valid = 1'b1;
                    resp_rdata = rdata_q;
                    resp_err   = err_q;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ysyx2400012_lsu.sv
// Bench for ysyx2400012_lsu: transaction-level memory model, per-cycle
// expected outputs, directed corner cases and randomized traffic.
module tb_ysyx2400012_lsu;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_rd_en;
    logic [31:0] mem_rd_addr;
    logic [31:0] mem_rd_data = 32'h0;
    logic        mem_wr_en;
    logic [31:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_wr_len;

    always #5 clock = ~clock;

    ysyx2400012_lsu dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_wen     (req_wen),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .mem_wr_len  (mem_wr_len)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // phys: what the DUT actually wrote; ref_mem: what it should have written
    logic [7:0] phys    [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    logic        chk_en = 1'b0;
    logic        e_ready, e_rvalid, e_err, e_rd_en, e_wr_en, e_load, e_store;
    logic [31:0] e_rdata, e_rd_addr, e_wr_addr, e_wr_data, e_wr_len;
    logic [31:0] seen_rdata = 32'h0;
    logic        seen_err = 1'b0;
    logic [31:0] seen_len = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] phys_byte(input logic [31:0] a);
        return phys.exists(a) ? phys[a] : 8'h00;
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    function automatic int nbytes(input logic [1:0] s);
        case (s)
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit model_err(input logic [31:0] a, input logic [1:0] s);
        int n;
        n = nbytes(s);
        if (n == 0) return 1'b1;
        if ((a % 32'(n)) != 0) return 1'b1;
        if (longint'(a) < 64'h8000_0000) return 1'b1;
        if (longint'(a) + longint'(n) > 64'h8800_0000) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] s,
                                               input bit uns);
        longint v;
        int     n;
        v = 0;
        n = nbytes(s);
        for (int i = 0; i < n; i++)
            v += longint'(ref_byte(a + 32'(i))) << (8 * i);
        if (!uns && v >= (longint'(1) << (8 * n - 1)))
            v -= longint'(1) << (8 * n);
        return v[31:0];
    endfunction

    task automatic exp_zero();
        e_ready = 0; e_rvalid = 0; e_err = 0; e_rdata = 0;
        e_rd_en = 0; e_wr_en = 0; e_load = 0; e_store = 0;
        e_rd_addr = 0; e_wr_addr = 0; e_wr_data = 0; e_wr_len = 0;
    endtask

    task automatic exp_idle();
        exp_zero();
        e_ready = 1;
    endtask

    // Memory read port: the addressed word is presented during the read cycle.
    always @(negedge clock) begin
        logic [31:0] w;
        w = $urandom;
        if (mem_rd_en === 1'b1)
            for (int i = 0; i < 4; i++) w[8*i +: 8] = phys_byte(mem_rd_addr + 32'(i));
        mem_rd_data = w;
    end

    always @(posedge clock) begin
        if (mem_wr_en === 1'b1)
            for (int i = 0; i < 4; i++)
                if (32'(i) < mem_wr_len) phys[mem_wr_addr + 32'(i)] = mem_wr_data[8*i +: 8];
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("req_ready", 32'(req_ready), 32'(e_ready));
            chk("resp_valid", 32'(resp_valid), 32'(e_rvalid));
            if (e_rvalid || !reset) begin
                chk("resp_rdata", resp_rdata, e_rdata);
                chk("resp_err", 32'(resp_err), 32'(e_err));
            end
            chk("mem_rd_en", 32'(mem_rd_en), 32'(e_rd_en));
            chk("mem_wr_en", 32'(mem_wr_en), 32'(e_wr_en));
            if (!e_store) chk("mem_rd_addr", mem_rd_addr, e_rd_addr);
            if (!e_load) begin
                chk("mem_wr_addr", mem_wr_addr, e_wr_addr);
                chk("mem_wr_data", mem_wr_data, e_wr_data);
                chk("mem_wr_len", mem_wr_len, e_wr_len);
            end
            if (resp_valid === 1'b1) begin
                seen_rdata = resp_rdata;
                seen_err   = resp_err;
            end
            if (mem_wr_en === 1'b1) seen_len = mem_wr_len;
        end
    end

    // Entered and left just after a rising edge with the DUT idle.
    task automatic do_req(input bit wen, input logic [31:0] a, input logic [31:0] wd,
                          input logic [1:0] s, input bit uns, input int hold);
        bit err;
        int n;
        err          = model_err(a, s);
        n            = nbytes(s);
        req_wen      = wen;
        req_addr     = a;
        req_wdata    = wd;
        req_size     = s;
        req_unsigned = uns;
        req_valid    = 1'b1;
        @(posedge clock); #1;
        req_valid    = 1'($urandom);
        req_wen      = 1'($urandom);
        req_addr     = $urandom;
        req_wdata    = $urandom;
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        exp_zero();
        if (!err) begin
            if (wen) begin
                e_wr_en   = 1; e_store = 1;
                e_wr_addr = a;
                e_wr_data = wd & 32'((64'd1 << (8 * n)) - 1);
                e_wr_len  = 32'(n);
                for (int i = 0; i < n; i++) ref_mem[a + 32'(i)] = wd[8*i +: 8];
            end else begin
                e_rd_en   = 1; e_load = 1;
                e_rd_addr = a & ~32'h3;
            end
            @(posedge clock); #1;
            exp_zero();
        end
        e_rvalid = 1;
        e_err    = err;
        e_rdata  = (err || wen) ? 32'h0 : model_load(a, s, uns);
        resp_ready = 1'b0;
        repeat (hold) begin @(posedge clock); #1; end
        resp_ready = 1'b1;
        @(posedge clock); #1;
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        exp_idle();
    endtask

    logic [31:0] edges [8] = '{32'h7FFF_FFFC, 32'h7FFF_FFFF, 32'h87FF_FFFC, 32'h87FF_FFFD,
                               32'h87FF_FFFE, 32'h87FF_FFFF, 32'h0000_0000, 32'hFFFF_FFFC};

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'h0;
        req_wdata = 32'h0; req_size = 2'd0; req_unsigned = 1'b0; resp_ready = 1'b0;
        @(posedge clock); #1;
        exp_zero();
        chk_en = 1'b1;
        @(posedge clock); #1;
        reset = 1'b1;
        exp_idle();
        @(posedge clock); #1;

        do_req(1, 32'h8000_0010, 32'hDEAD_BEEF, 2'd2, 0, 0);
        chk("lit_sw_len", seen_len, 32'd4);
        do_req(0, 32'h8000_0010, 32'h0, 2'd2, 0, 1);
        chk("lit_lw_data", seen_rdata, 32'hDEAD_BEEF);
        chk("lit_lw_err", 32'(seen_err), 32'd0);

        do_req(1, 32'h8000_0020, 32'h0000_80F0, 2'd2, 0, 0);
        do_req(0, 32'h8000_0020, 32'h0, 2'd0, 0, 0);
        chk("lit_lb", seen_rdata, 32'hFFFF_FFF0);
        do_req(0, 32'h8000_0021, 32'h0, 2'd0, 1, 0);
        chk("lit_lbu", seen_rdata, 32'h0000_0080);
        do_req(0, 32'h8000_0020, 32'h0, 2'd1, 0, 0);
        chk("lit_lh", seen_rdata, 32'hFFFF_80F0);

        do_req(0, 32'h8000_0002, 32'h0, 2'd2, 0, 0);
        chk("lit_lw_misalign", 32'(seen_err), 32'd1);
        do_req(0, 32'h8000_0001, 32'h0, 2'd1, 0, 0);
        chk("lit_lh_misalign", 32'(seen_err), 32'd1);
        do_req(1, 32'h8000_0000, 32'h1234_5678, 2'd3, 0, 0);
        chk("lit_size3", 32'(seen_err), 32'd1);

        do_req(0, 32'h7FFF_FFFC, 32'h0, 2'd2, 0, 0);
        chk("lit_below", 32'(seen_err), 32'd1);
        do_req(0, 32'h87FF_FFFD, 32'h0, 2'd2, 0, 0);
        chk("lit_above", 32'(seen_err), 32'd1);
        do_req(0, 32'h87FF_FFFC, 32'h0, 2'd2, 0, 0);
        chk("lit_top_ok", 32'(seen_err), 32'd0);

        do_req(0, 32'h8000_0020, 32'h0, 2'd2, 1, 5);
        chk("lit_bp_data", seen_rdata, 32'h0000_80F0);

        // Reset during the memory-read cycle abandons the load.
        req_wen = 1'b0; req_addr = 32'h8000_0020; req_size = 2'd2;
        req_unsigned = 1'b0; req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        reset = 1'b0;
        exp_zero();
        @(posedge clock); #1;
        reset = 1'b1;
        exp_idle();
        repeat (3) begin @(posedge clock); #1; end

        for (int k = 0; k < 300; k++) begin
            logic [31:0] a;
            logic [1:0]  s;
            if ($urandom_range(0, 7) == 0) a = edges[$urandom_range(0, 7)];
            else a = 32'h8000_0000 + $urandom_range(0, 31);
            s = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            do_req(1'($urandom), a, $urandom, s, 1'($urandom), int'($urandom_range(0, 3)));
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
